// File: rtl/othello_pkg.sv
// Shared definitions for the Othello turn-control slice.
//   turn_state_e      : controller states (IDLE, DETECT, EVAL, WRITE, COMMIT, OVER)
//   COORD_W           : board coordinate width (8x8 board -> 3 bits)
//   COUNT_W           : width of the accepted-move counter
//   MAX_MOVES_DEFAULT : number of accepted moves after which the game ends
//   max_int()         : elaboration-time helper for sizing counters
package othello_pkg;

    localparam int COORD_W           = 3;
    localparam int COUNT_W           = 7;
    localparam int MAX_MOVES_DEFAULT = 60;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DETECT = 3'd1,
        ST_EVAL   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_COMMIT = 3'd4,
        ST_OVER   = 3'd5
    } turn_state_e;

    function automatic int max_int(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/turn_controller_window_timer.sv
// window_timer: loadable down-counter used to time the detect and write
// windows. A load sets the count; the count then falls by one per cycle
// and parks at zero. done is high while the count equals 1, i.e. during
// the last cycle of a window that was loaded with N (N >= 1).
//   clock    : rising-edge clock
//   resetn   : synchronous active-low reset
//   load     : load load_val this cycle
//   load_val : window length in cycles
//   done     : last cycle of the current window
module window_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count_r;

    // Window count register: load on window entry, then count down to zero.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != {WIDTH{1'b0}}) begin
            count_r <= count_r - WIDTH'(1'b1);
        end
    end

    assign done = (count_r == WIDTH'(1'b1));

endmodule

// File: rtl/turn_controller.sv
// turn_controller: sequences one Othello turn against an external board
// storage. A place request opens a detect window, samples the legal
// direction mask, and (if legal) opens a write window before committing
// the move. Two consecutive passes, or reaching MAX_MOVES accepted moves,
// end the game. No board contents are held here.
//   clock, resetn     : rising-edge clock, synchronous active-low reset
//   place_req         : place a disk at cur_x/cur_y (honoured in IDLE only)
//   pass_req          : pass the turn (honoured in IDLE only, place wins)
//   cur_x, cur_y      : cursor coordinates
//   dir               : legal-direction mask, sampled in EVAL
//   detecten, writeen : detect / write windows to the board storage
//   x, y              : move coordinates, held from DETECT through COMMIT
//   side              : player to move
//   busy              : a move is in progress
//   accept, reject    : one-cycle move result pulses
//   move_count        : accepted moves (saturates at MAX_MOVES)
//   game_over         : game has ended; only reset leaves this
module turn_controller
    import othello_pkg::*;
#(
    parameter int DET_CYCLES = 10,
    parameter int WR_CYCLES  = 10,
    parameter int MAX_MOVES  = MAX_MOVES_DEFAULT
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               place_req,
    input  logic               pass_req,
    input  logic [COORD_W-1:0] cur_x,
    input  logic [COORD_W-1:0] cur_y,
    input  logic [7:0]         dir,
    output logic               detecten,
    output logic               writeen,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               side,
    output logic               busy,
    output logic               accept,
    output logic               reject,
    output logic [COUNT_W-1:0] move_count,
    output logic               game_over
);

    localparam int TIMER_W = $clog2(max_int(DET_CYCLES, WR_CYCLES) + 1);
    localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(MAX_MOVES);

    turn_state_e        state_r;
    turn_state_e        state_next_s;
    logic               timer_load_s;
    logic [TIMER_W-1:0] timer_val_s;
    logic               timer_done_s;
    logic [1:0]         pass_streak_r;
    logic               commit_enter_s;
    logic               pass_take_s;

    window_timer #(
        .WIDTH (TIMER_W)
    ) u_window_timer (
        .clock    (clock),
        .resetn   (resetn),
        .load     (timer_load_s),
        .load_val (timer_val_s),
        .done     (timer_done_s)
    );

    // Next-state decode and window-timer load control.
    always_comb begin
        state_next_s = state_r;
        timer_load_s = 1'b0;
        timer_val_s  = {TIMER_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (place_req) begin
                    state_next_s = ST_DETECT;
                    timer_load_s = 1'b1;
                    timer_val_s  = TIMER_W'(DET_CYCLES);
                end else if (pass_req) begin
                    // A pass while one is already pending ends the game.
                    if (pass_streak_r != 2'd0) begin
                        state_next_s = ST_OVER;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DETECT: begin
                if (timer_done_s) begin
                    state_next_s = ST_EVAL;
                end else begin
                    state_next_s = ST_DETECT;
                end
            end
            ST_EVAL: begin
                if (dir != 8'h00) begin
                    state_next_s = ST_WRITE;
                    timer_load_s = 1'b1;
                    timer_val_s  = TIMER_W'(WR_CYCLES);
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (timer_done_s) begin
                    state_next_s = ST_COMMIT;
                end else begin
                    state_next_s = ST_WRITE;
                end
            end
            ST_COMMIT: begin
                // move_count already holds the incremented value here.
                if (move_count >= MAX_COUNT) begin
                    state_next_s = ST_OVER;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_OVER: begin
                state_next_s = ST_OVER;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    assign commit_enter_s = (state_r == ST_WRITE) && (state_next_s == ST_COMMIT);
    assign pass_take_s    = (state_r == ST_IDLE) && !place_req && pass_req;

    // State register and state-decoded outputs, registered from next state
    // so each window enable is high exactly while the FSM sits in it.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            detecten  <= 1'b0;
            writeen   <= 1'b0;
            busy      <= 1'b0;
            game_over <= 1'b0;
            accept    <= 1'b0;
            reject    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            detecten  <= (state_next_s == ST_DETECT);
            writeen   <= (state_next_s == ST_WRITE);
            busy      <= (state_next_s != ST_IDLE) && (state_next_s != ST_OVER);
            game_over <= (state_next_s == ST_OVER);
            accept    <= commit_enter_s;
            // Reject shows in the cycle right after EVAL, when back in IDLE.
            reject    <= (state_r == ST_EVAL) && (dir == 8'h00);
        end
    end

    // Move datapath: coordinates, side to move, move count and pass streak.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            x             <= {COORD_W{1'b0}};
            y             <= {COORD_W{1'b0}};
            side          <= 1'b0;
            move_count    <= {COUNT_W{1'b0}};
            pass_streak_r <= 2'd0;
        end else begin
            if ((state_r == ST_IDLE) && place_req) begin
                x <= cur_x;
                y <= cur_y;
            end
            if (commit_enter_s) begin
                side          <= ~side;
                pass_streak_r <= 2'd0;
                if (move_count < MAX_COUNT) begin
                    move_count <= move_count + COUNT_W'(1'b1);
                end
            end else if (pass_take_s) begin
                side <= ~side;
                if (pass_streak_r != 2'd3) begin
                    pass_streak_r <= pass_streak_r + 2'd1;
                end
            end
        end
    end

endmodule

// File: doc/turn_controller.md
TURN_CONTROLLER -- requirements
Module: turn_controller

Interface
REQ-001 Parameter DET_CYCLES, default 10: cycles detecten is held high per detect window.
REQ-002 Parameter WR_CYCLES, default 10: cycles writeen is held high per write window.
REQ-003 Parameter MAX_MOVES, default 60: accepted moves after which the game ends.
REQ-004 clock  input  1  rising-edge system clock.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 place_req  input  1  single-cycle request to place a disk at cur_x/cur_y.
REQ-007 pass_req  input  1  single-cycle request to pass the turn.
REQ-008 cur_x, cur_y  input  3 each  cursor column and row.
REQ-009 dir  input  8  legal-direction mask returned by the board storage.
REQ-010 detecten, writeen  output  1 each  detect and write windows to the board storage.
REQ-011 x, y  output  3 each  latched move coordinates to the board storage.
REQ-012 side  output  1  player to move.
REQ-013 busy  output  1  high in every state except IDLE and OVER.
REQ-014 accept, reject  output  1 each  single-cycle move result pulses.
REQ-015 move_count  output  7  accepted moves since reset.
REQ-016 game_over  output  1  high while in OVER.

Function
REQ-017 States SHALL be IDLE, DETECT, EVAL, WRITE, COMMIT and OVER, all registered.
REQ-018 IDLE + place_req: latch cur_x/cur_y into x/y, go to DETECT next cycle.
REQ-019 DETECT: detecten high for exactly DET_CYCLES cycles, then go to EVAL.
REQ-020 EVAL: one cycle, detecten and writeen both low; sample dir.
REQ-021 EVAL exit, dir != 0: go to WRITE.
REQ-022 EVAL exit, dir == 0: reject high for that one cycle, side unchanged, go to IDLE.
REQ-023 WRITE: writeen high for exactly WR_CYCLES cycles, then go to COMMIT.
REQ-024 COMMIT: one cycle with writeen low. In that cycle: accept pulses, side toggles, move_count increments, pass streak clears.
REQ-025 COMMIT exit: go to OVER if move_count reaches MAX_MOVES, else IDLE.
REQ-026 IDLE + pass_req without place_req: side toggles and pass streak increments, with no board access.
REQ-027 The second consecutive pass SHALL enter OVER the next cycle.
REQ-028 place_req and pass_req asserted together in IDLE: place wins, pass is dropped.
REQ-029 Requests arriving in any state other than IDLE SHALL be ignored, not queued.
REQ-030 x and y SHALL stay constant from DETECT entry through COMMIT.
REQ-031 detecten and writeen SHALL never be high in the same cycle.
REQ-032 Each window SHALL be preceded by at least one cycle with its enable low, so downstream edge-detect logic fires once per window.
REQ-033 OVER is absorbing: only reset leaves it.
REQ-034 move_count SHALL saturate at MAX_MOVES.
REQ-035 The window counter is DET_CYCLES/WR_CYCLES wide enough, loads on state entry, and counts down to 1.

Reset
REQ-036 When resetn is low at a clock edge, state SHALL go to IDLE.
REQ-037 Reset values: side=0, x=0, y=0, detecten=0, writeen=0, busy=0, accept=0, reject=0, move_count=0, game_over=0, pass streak=0.
REQ-038 Reset mid-window SHALL drop detecten/writeen on the next edge, with no accept/reject pulse.

Structure
REQ-039 Shared package othello_pkg SHALL hold the state enum, MAX_MOVES default and board-coordinate width (3).
REQ-040 A single sub-module window_timer (loadable down-counter with a done flag) SHALL time both windows.
REQ-041 No board contents SHALL be stored here; legality comes only from dir.

Verification
REQ-042 Reset, then place_req at (2,3) with dir=8'h04 in EVAL -> detecten high 10 cycles, 1 gap, writeen high 10 cycles, accept once, side=1, move_count=1, x=2/y=3 throughout.
REQ-043 place_req with dir=8'h00 -> 10 detect cycles, reject once, writeen never high, side=0, move_count=0.
REQ-044 pass_req twice in IDLE with no move between -> side 0->1->0, game_over=1; later place_req ignored.
REQ-045 place_req and pass_req same cycle -> move sequence runs, pass streak stays 0, only one side toggle (at COMMIT).
REQ-046 resetn low on 5th writeen cycle -> next edge writeen=0, state IDLE, no accept, move_count=0.
REQ-047 MAX_MOVES=2, two legal moves -> game_over=1 after second COMMIT, move_count=2.
